// File: rtl/soc_ctrl_pkg.sv
// Shared types for the SoC controller clock/reset sequencing blocks.
// The optional status port build macro for the shutdown sequencer is
// SOC_CTRL_SHUTDOWN_STATUS_EN; the encoding below is what state_o reports.
package soc_ctrl_pkg;

    localparam int unsigned SHDN_STATE_W = 3;

    typedef enum logic [SHDN_STATE_W-1:0] {
        SHDN_RUN     = 3'd0,
        SHDN_GATE    = 3'd1,
        SHDN_RESET   = 3'd2,
        SHDN_OFF     = 3'd3,
        SHDN_RELEASE = 3'd4
    } soc_ctrl_shdn_state_e;

    // Largest of three delay parameters, used to size the shared timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/soc_ctrl_shdn_timer.sv
// Loadable down-counter for the shutdown sequencer.
// A load takes priority; otherwise the count decrements and parks at zero.
// zero_o is the terminal-count flag the FSM compares against.
module soc_ctrl_shdn_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, else count down to zero and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/soc_ctrl_clk_rst_shutdown_seq.sv
// Shutdown/restart sequencer for one gated clock/reset domain.
// Four-phase handshake: req high -> gate clock, wait, assert reset, wait,
// ack. req low -> release reset, wait, re-enable clock.
// Build option SOC_CTRL_SHUTDOWN_STATUS_EN adds registered state_o/busy_o.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | domain clocked and out of reset, waiting for req
// GATE    | clock gated, counting GATE_CYCLES before reset assertion
// RESET   | reset asserted, counting RST_CYCLES before ack
// OFF     | domain off, ack high, waiting for req to drop
// RELEASE | reset released, counting UNGATE_CYCLES before clock enable
module soc_ctrl_clk_rst_shutdown_seq
    import soc_ctrl_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 16,
    parameter int unsigned RST_CYCLES    = 32,
    parameter int unsigned UNGATE_CYCLES = 50
) (
    input  logic       ref_clk_i,
    input  logic       glb_arst_ni,
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       clk_en_i,
    input  logic       req_i,
    output logic       ack_o,
    output logic       clk_o,
    output logic       arst_no,
`ifdef SOC_CTRL_SHUTDOWN_STATUS_EN
    output logic [2:0] state_o,
    output logic       busy_o,
`endif
    output logic       clk_en_o
);

    localparam int unsigned CNT_MAX = max3(GATE_CYCLES, RST_CYCLES, UNGATE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    // Timer reload values: the state is left on the edge after the count hits
    // zero, so an N-cycle phase loads N-1.
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNGATE_LOAD = CNT_W'(UNGATE_CYCLES - 1);

    soc_ctrl_shdn_state_e state_q, state_d;
    logic                 en_int_q, en_int_d;
    logic                 rst_int_n_q, rst_int_n_d;
    logic                 ack_q, ack_d;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_value;
    logic                 tmr_zero;

    soc_ctrl_shdn_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk_i   (ref_clk_i),
        .rst_ni  (glb_arst_ni),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // Next-state and next-output decode; req is only looked at in RUN and OFF,
    // so every started phase runs to completion.
    always_comb begin
        state_d     = state_q;
        en_int_d    = en_int_q;
        rst_int_n_d = rst_int_n_q;
        ack_d       = ack_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        case (state_q)
            SHDN_RUN: begin
                if (req_i) begin
                    state_d   = SHDN_GATE;
                    en_int_d  = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = GATE_LOAD;
                end
            end
            SHDN_GATE: begin
                if (tmr_zero) begin
                    state_d     = SHDN_RESET;
                    rst_int_n_d = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_value   = RST_LOAD;
                end
            end
            SHDN_RESET: begin
                if (tmr_zero) begin
                    state_d = SHDN_OFF;
                    ack_d   = 1'b1;
                end
            end
            SHDN_OFF: begin
                if (!req_i) begin
                    state_d     = SHDN_RELEASE;
                    rst_int_n_d = 1'b1;
                    ack_d       = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_value   = UNGATE_LOAD;
                end
            end
            SHDN_RELEASE: begin
                if (tmr_zero) begin
                    state_d  = SHDN_RUN;
                    en_int_d = 1'b1;
                end
            end
            default: begin
                state_d     = SHDN_RUN;
                en_int_d    = 1'b1;
                rst_int_n_d = 1'b1;
                ack_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; global reset lands in RUN with the domain live.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            state_q     <= SHDN_RUN;
            en_int_q    <= 1'b1;
            rst_int_n_q <= 1'b1;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_int_q    <= en_int_d;
            rst_int_n_q <= rst_int_n_d;
            ack_q       <= ack_d;
        end
    end

    // Upstream enable/reset are ANDed in so they still act while the
    // sequencer sits in RUN; the reset path is purely combinational.
    assign clk_en_o = clk_en_i & en_int_q;
    assign clk_o    = clk_i & clk_en_o;
    assign arst_no  = arst_ni & rst_int_n_q;
    assign ack_o    = ack_q;

`ifdef SOC_CTRL_SHUTDOWN_STATUS_EN
    logic busy_q;

    // Busy is registered from the next state so it lines up with state_o.
    always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
        if (!glb_arst_ni) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d == SHDN_GATE) || (state_d == SHDN_RESET) ||
                      (state_d == SHDN_RELEASE);
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
`endif

endmodule
